multiport_regfile: RTL and testbench

MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

---
 rtl/multiport_regfile.sv | 129 ++++++++++++
 tb/tb_multiport_regfile.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/multiport_regfile.sv
// Purpose: 2-read/1-write register file with entry 0 hard-wired to zero, plus a sequential clear engine (optional write-first bypass via RF_BYPASS_EN).
// Latency: 1 cycle from read address to RD1/RD2; a clear takes 2**ADDR_W cycles, and BUSY is high for that long.
// Backpressure: none on reads; while BUSY is high, writes are dropped and read data is forced to 0.
module multiport_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLR,
    input  logic              WE,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              BUSY
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptrNext;
    logic              memWe;
    logic [ADDR_W-1:0] memWa;
    logic [DATA_W-1:0] memWd;
    logic [DATA_W-1:0] rd1Raw;
    logic [DATA_W-1:0] rd2Raw;
    logic [DATA_W-1:0] rd1Next;
    logic [DATA_W-1:0] rd2Next;

    assign BUSY = (state == CLEAR);

    // Raw array read per port: entry 0 is always zero; optional same-cycle write forwarding.
    always_comb begin
        rd1Raw = '0;
        rd2Raw = '0;
        if (RA1 != '0) begin
            rd1Raw = mem[RA1];
        end
        if (RA2 != '0) begin
            rd2Raw = mem[RA2];
        end
`ifdef RF_BYPASS_EN
        if (WE && (WA == RA1) && (RA1 != '0)) begin
            rd1Raw = WD;
        end
        if (WE && (WA == RA2) && (RA2 != '0)) begin
            rd2Raw = WD;
        end
`endif
    end

    // Next-state logic: clear sweep in CLEAR, normal read/write in IDLE.
    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        memWe     = 1'b0;
        memWa     = ptr;
        memWd     = '0;
        rd1Next   = '0;
        rd2Next   = '0;
        case (state)
            CLEAR: begin
                // Zero the entry under the pointer; CLR restarts the sweep from 0.
                memWe = 1'b1;
                memWa = ptr;
                if (CLR) begin
                    ptrNext = '0;
                end else begin
                    ptrNext = ptr + 1'b1;
                    if (ptr == {ADDR_W{1'b1}}) begin
                        stateNext = IDLE;
                    end
                end
            end
            IDLE: begin
                if (CLR) begin
                    // Any write issued alongside CLR is dropped, and read data is forced to 0.
                    stateNext = CLEAR;
                    ptrNext   = '0;
                end else begin
                    memWe   = WE && (WA != '0);
                    memWa   = WA;
                    memWd   = WD;
                    rd1Next = rd1Raw;
                    rd2Next = rd2Raw;
                end
            end
            default: begin
                stateNext = CLEAR;
                ptrNext   = '0;
            end
        endcase
    end

    // Control and read-data registers; reset parks the block at the start of a clear.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= CLEAR;
            ptr   <= '0;
            RD1   <= '0;
            RD2   <= '0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
            RD1   <= rd1Next;
            RD2   <= rd2Next;
        end
    end

    // Array write port; contents are left untouched while reset is held.
    always_ff @(posedge CLK) begin
        if (RST_N && memWe) begin
            mem[memWa] <= memWd;
        end
    end

endmodule

// File: tb/tb_multiport_regfile.sv
// Purpose: scoreboard bench for multiport_regfile covering reset, clear, read/write, zero entry and bypass.
// Latency: expectations target the edge after the stimulus cycle (1-cycle read latency).
// Backpressure: none; the monitor compares every cycle that has a queued expectation.
module tb_multiport_regfile;

    logic        CLK;
    logic        RST_N;
    logic        CLR;
    logic        WE;
    logic [4:0]  WA;
    logic [31:0] WD;
    logic [4:0]  RA1;
    logic [4:0]  RA2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic        BUSY;

    typedef struct {
        int          tgt;
        string       name;
        bit          c1;
        bit          c2;
        bit          cb;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb;
    } exp_t;

    exp_t expQ[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    multiport_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .CLR  (CLR),
        .WE   (WE),
        .WA   (WA),
        .WD   (WD),
        .RA1  (RA1),
        .RA2  (RA2),
        .RD1  (RD1),
        .RD2  (RD2),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: shortly after each edge, pop and compare the expectations aimed at this edge.
    always @(posedge CLK) begin
        #1;
        while (expQ.size() > 0 && expQ[0].tgt <= cyc) begin
            exp_t e;
            e = expQ.pop_front();
            if (e.tgt < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d missed, now %0d", e.name, e.tgt, cyc);
            end else begin
                if (e.c1) chk({e.name, ".RD1"}, RD1, e.e1);
                if (e.c2) chk({e.name, ".RD2"}, RD2, e.e2);
                if (e.cb) chk({e.name, ".BUSY"}, {31'd0, BUSY}, {31'd0, e.eb});
            end
        end
    end

    // One stimulus cycle: drive inputs at the falling edge and queue what the next edge must show.
    task automatic step(input logic rstn, input logic clr, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra1, input logic [4:0] ra2,
                        input string nm,
                        input bit c1, input logic [31:0] e1,
                        input bit c2, input logic [31:0] e2,
                        input bit cb, input logic eb);
        exp_t e;
        @(negedge CLK);
        RST_N = rstn;
        CLR   = clr;
        WE    = we;
        WA    = wa;
        WD    = wd;
        RA1   = ra1;
        RA2   = ra2;
        if (c1 || c2 || cb) begin
            e.tgt  = cyc + 1;
            e.name = nm;
            e.c1   = c1;
            e.c2   = c2;
            e.cb   = cb;
            e.e1   = e1;
            e.e2   = e2;
            e.eb   = eb;
            expQ.push_back(e);
        end
    endtask

    task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
        step(1'b1, 1'b0, 1'b1, wa, wd, 5'd0, 5'd0, "", 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input string nm, input logic [4:0] ra1, input logic [4:0] ra2,
                      input logic [31:0] e1, input logic [31:0] e2);
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, ra1, ra2, nm, 1, e1, 1, e2, 1, 1'b0);
    endtask

    // Full 32-edge clear: BUSY stays high until the last sweep edge; read data is 0 throughout.
    // A write attempted during the sweep must be ignored.
    task automatic clearSweep(input string nm);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_0055, 5'd4, 5'd9, nm,
                 1, 32'd0, 1, 32'd0, 1, (i < 31));
        end
    endtask

    initial begin
        RST_N = 1'b0;
        CLR   = 1'b0;
        WE    = 1'b0;
        WA    = '0;
        WD    = '0;
        RA1   = '0;
        RA2   = '0;

        // Reset holds the clear-start state, with priority over CLR and WE.
        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, "reset", 1, 32'd0, 1, 32'd0, 1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 5'd3, 32'h77, 5'd3, 5'd3, "reset_prio", 1, 32'd0, 1, 32'd0, 1, 1'b1);

        // Release: exactly 32 busy cycles.
        clearSweep("post_reset_clear");

        // Basic write then dual read of the same address.
        wr(5'd3, 32'hDEAD_BEEF);
        rd("rd_same_addr", 5'd3, 5'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        rd("clear_write_ignored", 5'd4, 5'd3, 32'd0, 32'hDEAD_BEEF);

        // Entry 0 discards writes and always reads zero.
        wr(5'd0, 32'h1234_5678);
        rd("zero_entry", 5'd0, 5'd0, 32'd0, 32'd0);

        // Same-cycle read/write hazard.
        wr(5'd7, 32'h0000_0011);
`ifdef RF_BYPASS_EN
        step(1'b1, 1'b0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7, "rw_hazard", 1, 32'h22, 1, 32'h22, 1, 1'b0);
`else
        step(1'b1, 1'b0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7, "rw_hazard", 1, 32'h11, 1, 32'h11, 1, 1'b0);
`endif
        rd("rw_after", 5'd7, 5'd0, 32'h22, 32'd0);
        rd("independent_ports", 5'd3, 5'd7, 32'hDEAD_BEEF, 32'h22);

        // Fill 1..31 and spot-check.
        for (int i = 1; i < 32; i++) begin
            wr(5'(i), 32'h100 + 32'(i));
        end
        rd("fill_a", 5'd1, 5'd31, 32'h101, 32'h11F);
        rd("fill_b", 5'd5, 5'd16, 32'h105, 32'h110);

        // CLR with a same-cycle write: write dropped, busy for 32 cycles, array zeroed.
        step(1'b1, 1'b1, 1'b1, 5'd5, 32'hAA, 5'd5, 5'd31, "clr_enter", 1, 32'd0, 1, 32'd0, 1, 1'b1);
        clearSweep("clr_sweep");
        for (int i = 0; i < 32; i++) begin
            rd("post_clr_zero", 5'(i), 5'(31 - i), 32'd0, 32'd0);
        end

        // Reset in the middle of a clear: state is held, then a full clear restarts.
        wr(5'd9, 32'h99);
        wr(5'd20, 32'h20);
        rd("pre_mid_reset", 5'd9, 5'd20, 32'h99, 32'h20);
        step(1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd20, "clr2_enter", 1, 32'd0, 1, 32'd0, 1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd20, "clr2_partial",
                 1, 32'd0, 1, 32'd0, 1, 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, 5'd20, 32'hBAD, 5'd9, 5'd20, "mid_clear_reset",
                 1, 32'd0, 1, 32'd0, 1, 1'b1);
        end
        clearSweep("restart_sweep");
        rd("restart_zero", 5'd9, 5'd20, 32'd0, 32'd0);
        wr(5'd12, 32'hCAFE_F00D);
        rd("post_restart_rw", 5'd12, 5'd3, 32'hCAFE_F00D, 32'd0);

        // Drain and confirm every expectation was consumed.
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "", 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "", 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
